speed_step_gen: RTL and testbench

Parametrised speed-controlled step counter: a prescaler generates a step tick at one of four runtime-selectable periods, and a CNT_W-bit counter advances on each tick in up, down, wrap or bounce mode. It drives LED/display animation speed and similar "move every N ms" behaviour in the board designs. Beyond the fixed single-rate up-counter it adds enable, synchronous clear, speed selection, direction and bounce modes, and tick/wrap status pulses.

---
 rtl/speed_step_gen.sv | 141 ++++++++++++++
 tb/tb_speed_step_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/speed_step_gen.sv
`default_nettype none
// ============================================================================
// Module   : speed_step_gen
// Brief    : Prescaled step counter with four runtime-selectable step periods,
//            up/down direction, wrap or bounce (ping-pong) counting, and
//            registered tick/wrap status pulses.
// Revision : 1.0 - initial release
// ============================================================================
module speed_step_gen #(
  parameter int CNT_W = 6,
  parameter int PRE_W = 26,
  parameter int T0    = 12_500_000,
  parameter int T1    = 25_000_000,
  parameter int T2    = 6_250_000,
  parameter int T3    = 3_125_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       speed_sel,
  input  logic             dir,
  input  logic             bounce,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             wrap,
  output logic             cur_dir
);

  // Terminal prescaler values (period - 1); Tn <= 2^PRE_W keeps these in range.
  localparam logic [PRE_W-1:0] T0_M1   = PRE_W'(T0 - 1);
  localparam logic [PRE_W-1:0] T1_M1   = PRE_W'(T1 - 1);
  localparam logic [PRE_W-1:0] T2_M1   = PRE_W'(T2 - 1);
  localparam logic [PRE_W-1:0] T3_M1   = PRE_W'(T3 - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PRE_W-1:0] pre_q,  pre_d;
  logic [1:0]       sel_q,  sel_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             dir_q,  dir_d;
  logic [PRE_W-1:0] term_w;
  logic             up_w;

  // Terminal count of the currently registered speed selection
  always_comb begin
    term_w = T0_M1;
    case (sel_q)
      2'd0:    term_w = T0_M1;
      2'd1:    term_w = T1_M1;
      2'd2:    term_w = T2_M1;
      default: term_w = T3_M1;
    endcase
  end

  // Next-state: clear > speed change > disabled hold > normal prescale/step
  always_comb begin
    pre_d  = pre_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    // Bounce mode steers by the internal direction; wrap mode by the port.
    up_w   = bounce ? ~dir_q : ~dir;

    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
      sel_d = speed_sel;
      dir_d = dir;
    end else if (speed_sel != sel_q) begin
      // New period is counted from this edge; no step is taken here.
      sel_d = speed_sel;
      pre_d = '0;
      if (en && !bounce) dir_d = dir;
    end else if (en) begin
      if (!bounce) dir_d = dir;
      // >= rather than == recovers if pre ever lands past the terminal count.
      if (pre_q >= term_w) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (!bounce) begin
          if (up_w) begin
            cnt_d  = cnt_q + CNT_ONE;
            wrap_d = (cnt_q == CNT_MAX);
          end else begin
            cnt_d  = cnt_q - CNT_ONE;
            wrap_d = (cnt_q == '0);
          end
        end else if (up_w) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d  = CNT_MAX - CNT_ONE;
            dir_d  = 1'b1;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d  = CNT_ONE;
            dir_d  = 1'b0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      sel_q  <= 2'd0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      dir_q  <= dir_d;
    end
  end

  assign cnt     = cnt_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign cur_dir = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_speed_step_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_speed_step_gen
// Brief    : Directed self-checking bench for speed_step_gen
//            (CNT_W=3, T0=4, T1=2, T2=8, T3=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_speed_step_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic       dir = 1'b0;
  logic       bounce = 1'b0;
  logic [2:0] cnt;
  logic       tick;
  logic       wrap;
  logic       cur_dir;

  int n_tests = 0;
  int n_fail  = 0;

  speed_step_gen #(
    .CNT_W(3), .PRE_W(4), .T0(4), .T1(2), .T2(8), .T3(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .speed_sel(speed_sel),
    .dir(dir), .bounce(bounce), .cnt(cnt), .tick(tick), .wrap(wrap),
    .cur_dir(cur_dir)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n-1 quiet edges, then an edge that must tick
  task automatic run_to_tick(input int n, input string tag);
    for (int i = 0; i < n - 1; i++) begin
      step();
      check({tag, "_quiet"}, {30'd0, tick, wrap}, 32'd0);
    end
    step();
    check({tag, "_tick"}, {31'd0, tick}, 32'd1);
  endtask

  // Apply reset between edges, release it, with given static controls
  task automatic do_reset(input logic d, input logic b, input logic [1:0] s);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en = 1'b1; clr = 1'b0; dir = d; bounce = b; speed_sel = s;
    #3;
    rst_n = 1'b1;
  endtask

  logic [2:0] b_cnt [15] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                             3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
  logic       b_dir [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    // Reset state
    #2;
    check("reset_cnt",  {29'd0, cnt}, 32'd0);
    check("reset_flags", {29'd0, tick, wrap, cur_dir}, 32'd0);

    // Wrap up, sel=0: ticks every 4 edges, cnt 1..7,0, wrap only at 7->0
    do_reset(1'b0, 1'b0, 2'd0);
    for (int k = 1; k <= 8; k++) begin
      run_to_tick(4, "up");
      check("up_cnt",  {29'd0, cnt}, k % 8);
      check("up_wrap", {31'd0, wrap}, (k == 8) ? 32'd1 : 32'd0);
    end

    // Wrap down: first tick 0->7 with wrap, then 6
    do_reset(1'b1, 1'b0, 2'd0);
    run_to_tick(4, "dn1");
    check("dn1_cnt", {29'd0, cnt}, 32'd7);
    check("dn1_wrap", {31'd0, wrap}, 32'd1);
    check("dn1_dir", {31'd0, cur_dir}, 32'd1);
    run_to_tick(4, "dn2");
    check("dn2_cnt", {29'd0, cnt}, 32'd6);
    check("dn2_wrap", {31'd0, wrap}, 32'd0);

    // Bounce: dir port toggled mid-run must have no effect
    do_reset(1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 15; k++) begin
      if (k == 3) dir = 1'b1;
      if (k == 10) dir = 1'b0;
      run_to_tick(4, "bnc");
      check("bnc_cnt", {29'd0, cnt}, {29'd0, b_cnt[k]});
      check("bnc_dir", {31'd0, cur_dir}, {31'd0, b_dir[k]});
      check("bnc_wrap", {31'd0, wrap}, (k == 7 || k == 14) ? 32'd1 : 32'd0);
    end

    // Speed change at pre=2: no tick on change edge, next tick 8 edges later
    do_reset(1'b0, 1'b0, 2'd0);
    step(); step();
    speed_sel = 2'd2;
    step();
    check("spd_chg_tick", {31'd0, tick}, 32'd0);
    run_to_tick(8, "spd8");
    check("spd8_cnt", {29'd0, cnt}, 32'd1);
    speed_sel = 2'd1;
    step();
    check("spd_chg2_tick", {31'd0, tick}, 32'd0);
    run_to_tick(2, "spd2a");
    check("spd2a_cnt", {29'd0, cnt}, 32'd2);
    run_to_tick(2, "spd2b");
    check("spd2b_cnt", {29'd0, cnt}, 32'd3);

    // Enable hold for 5 cycles mid-period stretches the interval by 5
    do_reset(1'b0, 1'b0, 2'd0);
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_tick", {31'd0, tick}, 32'd0);
      check("hold_cnt", {29'd0, cnt}, 32'd0);
    end
    en = 1'b1;
    run_to_tick(2, "hold_resume");
    check("hold_resume_cnt", {29'd0, cnt}, 32'd1);

    // Clear with cnt=5, pre=3: cnt=0 next cycle, next tick 4 edges later
    do_reset(1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) run_to_tick(4, "clr_pre");
    check("clr_pre_cnt", {29'd0, cnt}, 32'd5);
    step(); step(); step();
    clr = 1'b1;
    step();
    check("clr_cnt", {29'd0, cnt}, 32'd0);
    check("clr_tick", {31'd0, tick}, 32'd0);
    clr = 1'b0;
    run_to_tick(4, "clr_after");
    check("clr_after_cnt", {29'd0, cnt}, 32'd1);

    // Asynchronous reset mid-period with sel=1 active
    speed_sel = 2'd1;
    step();
    run_to_tick(2, "rst_pre");
    check("rst_pre_cnt", {29'd0, cnt}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", {29'd0, cnt}, 32'd0);
    check("async_rst_flags", {29'd0, tick, wrap, cur_dir}, 32'd0);
    #2;
    rst_n = 1'b1;
    // sel_q back at 0: first edge is a speed change, then 2-edge period
    run_to_tick(3, "rst_sel");
    check("rst_sel_cnt", {29'd0, cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
